output_tx_unit: RTL and testbench
=================================

Name: output_tx_unit

Overview:
- Output-side peripheral for the Mano computer.
- Holds the 8-bit output register OUTR and its flag FGO.
- When the CPU executes OUT (AC[7:0] -> OUTR), the block serialises the character onto a single TXD line as an 8N1 frame.
- FGO rises again once the frame is complete. The CPU polls FGO with SKO or takes an interrupt on it. This block is the transmit counterpart to the input register/FGI path.

Parameters:
- CLKS_PER_BIT, 16, CLK cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8, character width; fixed at 8 for Mano OUTR and not otherwise supported.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- NCLR  input  1  synchronous active-low clear, sampled on rising CLK.
- D  input  8  character from AC[7:0].
- LD  input  1  load strobe from the OUT instruction decode; one-cycle pulse.
- FGO  output  1  output flag; 1 = OUTR empty and ready for a new character.
- TXD  output  1  serial line; idles high.
- BUSY  output  1  1 while a frame is in progress; always the complement of FGO.

Behaviour:
- Reset: NCLR=0 at a rising edge forces state=IDLE, OUTR=0, FGO=1, TXD=1, BUSY=0, baud and bit counters=0. This takes priority over LD.
- Power-up initial values equal the reset values.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - TXD=1, FGO=1.
  - At an edge with LD=1: OUTR<=D, TXD<=0, FGO<=0, baud counter<=0, state<=START.
  - TXD goes low on the same edge that samples LD (zero-cycle latency after the capture edge).
- START: TXD held 0 for exactly CLKS_PER_BIT cycles. On the last cycle: state<=DATA, bit index<=0, TXD<=OUTR[0].
- DATA:
  - Each bit held exactly CLKS_PER_BIT cycles, LSB first.
  - At the end of bit i<7: TXD<=OUTR[i+1] and index increments.
  - At the end of bit 7: TXD<=1, state<=STOP.
- STOP:
  - TXD=1 for CLKS_PER_BIT cycles.
  - At the end: state<=IDLE, FGO<=1.
- Frame timing: FGO stays 0 for exactly 10*CLKS_PER_BIT cycles after the capture edge.
- Baud counter counts 0..CLKS_PER_BIT-1, then wraps to 0. Its width is $clog2(CLKS_PER_BIT).
- OUTR stays stable throughout the frame; a shift-out of a copy is permitted, but OUTR itself is not disturbed.
- LD while FGO=0 (including the final STOP cycle) is ignored: OUTR is unchanged and the frame is unaffected. Software must poll FGO.
- LD in the first IDLE cycle after FGO rises is accepted. Back-to-back frames therefore have no extra idle bits.
- NCLR=0 mid-frame aborts immediately. TXD=1 and FGO=1 from that edge on; the partial frame is not resumed.
- NCLR=0 together with LD: the clear wins and the character is dropped.
- D is sampled only on an accepted LD edge; other D changes are don't-care.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - OUTR width constant 8;
  - frame length constant 10 bits.
- One sub-module: tx_baud_counter. It has a CLKS_PER_BIT parameter, inputs CLK, NCLR, and a clear pulse on frame start, and emits a one-cycle bit_done tick.
- FSM, OUTR and flag logic stay in the top module.

Test Plan:
- Reset then idle 20 cycles -> FGO=1, TXD=1, BUSY=0 throughout.
- CLKS_PER_BIT=4, LD with D=8'h41 -> TXD=0,1,0,0,0,0,0,1,0,1, each held exactly 4 cycles. FGO=0 for 40 cycles, then 1.
- D=8'h55 frame, second LD with D=8'hFF on cycle 20 -> second load ignored; frame bits still 1,0,1,0,1,0,1,0 LSB first.
- LD asserted on the first cycle FGO=1 after an 8'h00 frame, D=8'hA5 -> new start bit begins immediately. Total 80 cycles with no idle gap; second payload bits 1,0,1,0,0,1,0,1.
- NCLR=0 for one cycle during DATA bit 3 -> TXD=1 and FGO=1 at that edge, state IDLE. A subsequent LD with 8'h0F transmits a complete, correct frame.
- NCLR=0 with LD=1 and D=8'h33 on the same edge -> FGO stays 1, TXD stays 1, no frame produced.

Source files
------------

// File: rtl/output_tx_unit_pkg.sv
// Shared definitions for the Mano output transmit unit.
// - tx_state_t : FSM state encoding (also exposed on the STATE debug port)
// - OUTR_W     : width of the output register OUTR
// - FRAME_BITS : serial frame length in bit periods (start + 8 data + stop)
package output_tx_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int OUTR_W     = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/output_tx_unit_baud.sv
// Bit-period timer for the transmit unit.
// Ports:
//   CLK      : system clock
//   NCLR     : synchronous active-low clear
//   clr      : restart the bit period (asserted on the frame-capture edge)
//   bit_done : one-cycle tick during the last cycle of each bit period
// The count runs 0..CLKS_PER_BIT-1 and wraps. It free-runs while idle; the
// FSM ignores the tick outside a frame and realigns it with clr at capture.
module tx_baud_counter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic CLK,
  input  logic NCLR,
  input  logic clr,
  output logic bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!NCLR) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_done = (cnt == LAST);

endmodule

// File: rtl/output_tx_unit.sv
// Mano computer output peripheral: OUTR register, FGO flag and an 8N1
// serial transmitter on TXD.
// Ports:
//   CLK   : system clock, all state updates on the rising edge
//   NCLR  : synchronous active-low clear, wins over LD
//   D     : character from AC[7:0], sampled only on an accepted LD
//   LD    : one-cycle load strobe from OUT decode
//   FGO   : 1 = OUTR empty, ready for a new character
//   TXD   : serial line, idles high
//   BUSY  : frame in progress, always ~FGO
//   STATE : current FSM state (debug visibility)
// Handshake: LD is accepted only on an edge where FGO=1; LD while FGO=0 is
// dropped without effect, so software must poll FGO (or use its interrupt).
module output_tx_unit
  import output_tx_unit_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = OUTR_W
) (
  input  logic                 CLK,
  input  logic                 NCLR,
  input  logic [DATA_BITS-1:0] D,
  input  logic                 LD,
  output logic                 FGO,
  output logic                 TXD,
  output logic                 BUSY,
  output logic [1:0]           STATE
);

  tx_state_t            state, state_n;
  logic [DATA_BITS-1:0] outr, outr_n;
  logic                 fgo, fgo_n;
  logic                 txd, txd_n;
  logic [2:0]           idx, idx_n;
  logic                 baud_clr;
  logic                 bit_done;

  tx_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .CLK      (CLK),
    .NCLR     (NCLR),
    .clr      (baud_clr),
    .bit_done (bit_done)
  );

  always_ff @(posedge CLK) begin
    if (!NCLR) begin
      state <= IDLE;
      outr  <= '0;
      fgo   <= 1'b1;
      txd   <= 1'b1;
      idx   <= '0;
    end else begin
      state <= state_n;
      outr  <= outr_n;
      fgo   <= fgo_n;
      txd   <= txd_n;
      idx   <= idx_n;
    end
  end

  // TXD is registered: each bit value is loaded on the edge that ends the
  // previous bit, so the start bit appears on the very edge that captures LD.
  always_comb begin
    state_n  = state;
    outr_n   = outr;
    fgo_n    = fgo;
    txd_n    = txd;
    idx_n    = idx;
    baud_clr = 1'b0;
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        fgo_n = 1'b1;
        if (LD) begin
          outr_n   = D;
          txd_n    = 1'b0;
          fgo_n    = 1'b0;
          baud_clr = 1'b1;
          state_n  = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_n = DATA;
          idx_n   = '0;
          txd_n   = outr[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx == 3'(DATA_BITS - 1)) begin
            txd_n   = 1'b1;
            state_n = STOP;
          end else begin
            idx_n = idx + 3'd1;
            txd_n = outr[idx + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_n = IDLE;
          fgo_n   = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
        fgo_n   = 1'b1;
      end
    endcase
  end

  assign FGO   = fgo;
  assign TXD   = txd;
  assign BUSY  = ~fgo;
  assign STATE = state;

endmodule

// File: tb/tb_output_tx_unit.sv
// Bench for output_tx_unit with CLKS_PER_BIT=4.
// The reference model tracks only "frame active" and "cycles since capture";
// expected TXD/FGO/BUSY/STATE are derived arithmetically from that position in
// the 10-bit frame. A receiver samples TXD mid-bit and compares each finished
// character against the expected queue.
module tb_output_tx_unit;

  localparam int CPB   = 4;
  localparam int FRAME = 10;

  logic       CLK;
  logic       NCLR;
  logic [7:0] D;
  logic       LD;
  logic       FGO;
  logic       TXD;
  logic       BUSY;
  logic [1:0] STATE;

  output_tx_unit #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK   (CLK),
    .NCLR  (NCLR),
    .D     (D),
    .LD    (LD),
    .FGO   (FGO),
    .TXD   (TXD),
    .BUSY  (BUSY),
    .STATE (STATE)
  );

  // clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // reference model
  bit         m_active = 1'b0;
  int         m_t      = 0;
  logic [7:0] m_ch     = 8'h00;
  logic [7:0] rx       = 8'h00;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [7:0] rnd8();
    return 8'($urandom_range(0, 255));
  endfunction

  // driver: apply inputs for one edge, advance the model, check outputs
  task automatic step(input logic n, input logic l, input logic [7:0] dd);
    logic       e_txd;
    logic [1:0] e_state;
    int         bi;
    NCLR = n;
    LD   = l;
    D    = dd;
    @(posedge CLK);
    if (!n) begin
      if (m_active) exp_q.delete();
      m_active = 1'b0;
    end else if (m_active) begin
      m_t++;
      if (m_t == FRAME * CPB) m_active = 1'b0;
    end else if (l) begin
      m_active = 1'b1;
      m_t      = 0;
      m_ch     = dd;
      exp_q.push_back(dd);
    end
    #1;
    bi = m_t / CPB;
    if (!m_active)            begin e_txd = 1'b1;         e_state = 2'd0; end
    else if (bi == 0)         begin e_txd = 1'b0;         e_state = 2'd1; end
    else if (bi <= 8)         begin e_txd = m_ch[bi - 1]; e_state = 2'd2; end
    else                      begin e_txd = 1'b1;         e_state = 2'd3; end
    chk("txd",   32'(TXD),   32'(e_txd));
    chk("fgo",   32'(FGO),   32'(!m_active));
    chk("busy",  32'(BUSY),  32'(m_active));
    chk("state", 32'(STATE), 32'(e_state));
    // mid-bit receiver
    if (m_active && (m_t % CPB) == CPB / 2) begin
      if (bi >= 1 && bi <= 8) rx[bi - 1] = TXD;
      if (bi == 9) begin
        if (exp_q.size() == 0) chk("frame_queue", 32'd0, 32'd1);
        else chk("frame", 32'(rx), 32'(exp_q.pop_front()));
      end
    end
  endtask

  // one frame from capture to FGO rising, optional LD noise while busy
  task automatic run_frame(input logic [7:0] ch, input bit noise);
    step(1'b1, 1'b1, ch);
    for (int i = 0; i < FRAME * CPB; i++)
      step(1'b1, noise ? ($urandom_range(0, 3) == 0) : 1'b0, rnd8());
  endtask

  initial begin
    NCLR = 1'b0;
    LD   = 1'b0;
    D    = 8'h00;

    // reset, then idle
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hC3);
    repeat (20) step(1'b1, 1'b0, rnd8());

    // basic frame 0x41
    run_frame(8'h41, 1'b0);
    repeat (3) step(1'b1, 1'b0, rnd8());

    // 0x55 with an ignored load at cycle 20 and in the last STOP cycle
    step(1'b1, 1'b1, 8'h55);
    for (int i = 1; i <= FRAME * CPB; i++)
      step(1'b1, (i == 20 || i == FRAME * CPB), 8'hFF);
    repeat (2) step(1'b1, 1'b0, rnd8());

    // back-to-back 0x00 then 0xA5, no idle gap
    run_frame(8'h00, 1'b0);
    run_frame(8'hA5, 1'b0);
    step(1'b1, 1'b0, rnd8());

    // abort during DATA bit 3, then a clean 0x0F frame
    step(1'b1, 1'b1, rnd8());
    repeat (CPB + 3 * CPB + 1) step(1'b1, 1'b0, rnd8());
    step(1'b0, 1'b0, rnd8());
    repeat (3) step(1'b1, 1'b0, rnd8());
    run_frame(8'h0F, 1'b0);

    // clear together with load: character dropped
    step(1'b0, 1'b1, 8'h33);
    repeat (10) step(1'b1, 1'b0, rnd8());

    // randomized frames with random gaps and LD noise while busy
    for (int f = 0; f < 8; f++) begin
      run_frame(rnd8(), 1'b1);
      repeat ($urandom_range(0, 5)) step(1'b1, 1'b0, rnd8());
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
